// File: rtl/req_ack_mon_pkg.sv
// req_ack_monitor shared types.
// Checking-mode and per-channel state encodings.
package req_ack_mon_pkg;

    typedef enum logic [1:0] {
        RAM_UNTIL,
        RAM_S_UNTIL,
        RAM_S_UNTIL_WITH
    } ram_mode_e;

    typedef enum logic {
        CH_IDLE,
        CH_WAIT
    } ch_state_e;

endpackage

// File: rtl/req_ack_mon_ch.sv
// One req/ack channel checker.
// Edge detect, FSM, latency counter, max/sticky records.
module req_ack_mon_ch
    import req_ack_mon_pkg::*;
#(
    parameter ram_mode_e MODE    = RAM_S_UNTIL,
    parameter int        TIMEOUT = 16,
    parameter int        LAT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             ack_i,
    input  logic             clr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_drop_o,
    output logic             err_timeout_o,
    output logic             err_sticky_o,
    output logic [LAT_W-1:0] max_lat_o
);

    localparam logic [LAT_W-1:0] TO_V    = LAT_W'(TIMEOUT);
    localparam logic [LAT_W-1:0] CNT_MAX = '1;
    localparam logic [LAT_W-1:0] ONE     = LAT_W'(1);
    localparam bit STRONG = (MODE != RAM_UNTIL);
    localparam bit WITH   = (MODE == RAM_S_UNTIL_WITH);

    ch_state_e        state;
    logic [LAT_W-1:0] cnt;
    logic             req_q;
    logic             ack_q;

    logic             rose_req;
    logic             rose_ack;
    logic             ev_done;
    logic             ev_drop;
    logic             ev_to;
    logic [LAT_W-1:0] ev_lat;

    // Decide this edge's outcome from current state and input edges.
    always_comb begin
        rose_req = req_i & ~req_q;
        rose_ack = ack_i & ~ack_q;
        ev_done  = 1'b0;
        ev_drop  = 1'b0;
        ev_to    = 1'b0;
        ev_lat   = '0;
        unique case (state)
            CH_IDLE: begin
                if (rose_req && rose_ack) begin
                    ev_done = 1'b1;
                end
            end
            CH_WAIT: begin
                if (rose_ack) begin
                    if (WITH && !req_i) begin
                        ev_drop = 1'b1;
                    end else begin
                        ev_done = 1'b1;
                        ev_lat  = cnt;
                    end
                end else if (!req_i) begin
                    ev_drop = 1'b1;
                end else if (STRONG && cnt == TO_V) begin
                    ev_to = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Channel FSM and latency counter; busy mirrors WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CH_IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
        end else begin
            unique case (state)
                CH_IDLE: begin
                    if (rose_req && !rose_ack) begin
                        state  <= CH_WAIT;
                        cnt    <= ONE;
                        busy_o <= 1'b1;
                    end
                end
                CH_WAIT: begin
                    if (ev_done || ev_drop || ev_to) begin
                        state  <= CH_IDLE;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state  <= CH_IDLE;
                    cnt    <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Edge history and one-cycle event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q         <= 1'b0;
            ack_q         <= 1'b0;
            done_o        <= 1'b0;
            err_drop_o    <= 1'b0;
            err_timeout_o <= 1'b0;
        end else begin
            req_q         <= req_i;
            ack_q         <= ack_i;
            done_o        <= ev_done;
            err_drop_o    <= ev_drop;
            err_timeout_o <= ev_to;
        end
    end

    // Sticky error and worst latency; a same-edge event beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_o <= 1'b0;
            max_lat_o    <= '0;
        end else begin
            if (clr_i) begin
                err_sticky_o <= ev_drop | ev_to;
            end else begin
                err_sticky_o <= err_sticky_o | ev_drop | ev_to;
            end
            if (ev_done && (clr_i || ev_lat > max_lat_o)) begin
                max_lat_o <= ev_lat;
            end else if (clr_i) begin
                max_lat_o <= '0;
            end
        end
    end

endmodule

// File: rtl/req_ack_monitor.sv
// Multi-channel req/ack handshake monitor.
// Replicates one independent checker per channel.
module req_ack_monitor
    import req_ack_mon_pkg::*;
#(
    parameter int        NUM_CH  = 4,
    parameter ram_mode_e MODE    = RAM_S_UNTIL,
    parameter int        TIMEOUT = 16,
    parameter int        LAT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req_i,
    input  logic [NUM_CH-1:0]       ack_i,
    input  logic                    clr_i,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH-1:0]       err_drop_o,
    output logic [NUM_CH-1:0]       err_timeout_o,
    output logic [NUM_CH-1:0]       err_sticky_o,
    output logic [NUM_CH*LAT_W-1:0] max_lat_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        req_ack_mon_ch #(
            .MODE    (MODE),
            .TIMEOUT (TIMEOUT),
            .LAT_W   (LAT_W)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .req_i         (req_i[c]),
            .ack_i         (ack_i[c]),
            .clr_i         (clr_i),
            .busy_o        (busy_o[c]),
            .done_o        (done_o[c]),
            .err_drop_o    (err_drop_o[c]),
            .err_timeout_o (err_timeout_o[c]),
            .err_sticky_o  (err_sticky_o[c]),
            .max_lat_o     (max_lat_o[c*LAT_W +: LAT_W])
        );
    end

endmodule

// File: doc/req_ack_monitor.md
# req_ack_monitor

Synthesisable, parametrised monitor for multi-channel req/ack handshakes that checks "req held until ack rises" in hardware. It reports completions, latencies and violations per channel. The three checking flavours (weak until, strong until, strong until-with) are selectable by parameter, and strong modes add a timeout. It sits beside any req/ack producer/consumer pair as an always-on checker feeding a status/debug register block.

## Interface
- `NUM_CH`, 4: number of independent req/ack channels.
- `MODE`, `RAM_S_UNTIL`: `RAM_UNTIL` (weak, no timeout), `RAM_S_UNTIL` (timeout enforced), `RAM_S_UNTIL_WITH` (timeout enforced and req required in the ack cycle).
- `TIMEOUT`, 16: maximum accepted latency in cycles; must be ≥ 1 and < 2^LAT_W.
- `LAT_W`, 8: latency counter width.
- `clk` in 1: single clock, all sampling on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_i` in NUM_CH: request per channel.
- `ack_i` in NUM_CH: acknowledge per channel.
- `clr_i` in 1: clears sticky errors and max-latency records.
- `busy_o` out NUM_CH: channel is waiting for ack.
- `done_o` out NUM_CH: one-cycle pulse, handshake completed legally.
- `err_drop_o` out NUM_CH: one-cycle pulse, req fell before a legal ack.
- `err_timeout_o` out NUM_CH: one-cycle pulse, no ack within TIMEOUT.
- `err_sticky_o` out NUM_CH: OR of all past errors since reset or clear.
- `max_lat_o` out NUM_CH*LAT_W: per-channel worst completed latency, channel c at bits [c*LAT_W +: LAT_W].

## Operation
- Edge detection uses registered `req_q` and `ack_q`, both reset to 0.
  - rose(x) = x & ~x_q.
  - req high at the first edge after reset counts as a rose.
- Per-channel FSM has two states: IDLE and WAIT. `cnt` is LAT_W bits.
- IDLE:
  - rose(req) & rose(ack) at the same edge: done with latency 0; stay IDLE.
  - rose(req) alone: go to WAIT with cnt=1.
  - ack activity in IDLE is ignored.
- WAIT, evaluated at each edge in priority order:
  1. rose(ack):
     - `RAM_S_UNTIL_WITH` with req=0: err_drop.
     - Otherwise: done with latency=cnt; update max_lat if cnt > max_lat.
     - Either way, go to IDLE.
  2. req=0: err_drop; go to IDLE.
  3. Strong modes with cnt==TIMEOUT: err_timeout; go to IDLE.
  4. Otherwise: cnt increments, saturating at 2^LAT_W−1 in `RAM_UNTIL`.
- Weak mode never times out; `busy_o` stays 1 indefinitely while req is held.
- In `RAM_UNTIL`/`RAM_S_UNTIL`, req may be low in the ack-rise cycle.
- After an error or done, req must fall and rise again to start a new check. A held-high req does not retrigger.
- Channels are fully independent; no cross-channel arbitration.
- `clr_i` zeroes all `err_sticky_o` and `max_lat_o` bits.
  - An error detected at the same edge as `clr_i` wins: that sticky bit is set.
  - A done at the same edge as `clr_i` loads max_lat with its latency.

## Timing
- All outputs are registered. An event decided at edge k is visible from just after edge k until edge k+1.
- Latency = number of edges from the rose(req) edge to the rose(ack) edge.
  - Accepted range is 0..TIMEOUT in strong modes.
  - Timeout pulse follows edge E0+TIMEOUT if no ack has risen by then.
- `busy_o` = 1 from the edge after E0 through the terminating edge, exclusive.
- Reset values: `busy_o`, `done_o`, `err_*`, `max_lat_o` are all 0; FSMs in IDLE; cnt=0.
- Reset asserted mid-WAIT drops the transaction silently: no pulse, no sticky.

## Structure
- Package `req_ack_mon_pkg`:
  - `ram_mode_e` enum (`RAM_UNTIL`, `RAM_S_UNTIL`, `RAM_S_UNTIL_WITH`).
  - Per-channel state enum (`CH_IDLE`, `CH_WAIT`).
- Sub-module `req_ack_mon_ch`: one channel containing edge registers, FSM, counter and max/sticky registers. It is instantiated NUM_CH times in a generate loop.
- The top level only slices buses and fans out `clr_i`.

## Test plan
Configuration: NUM_CH=2, TIMEOUT=4, LAT_W=4.

- `RAM_S_UNTIL`, ch0: req rises at edge 10 and is held, ack rises at edge 13 → done_o[0] pulse after edge 13, max_lat ch0=3, busy_o[0] high after edges 10–12, no errors.
- Drop: req rises at edge 10 and falls at edge 12, no ack → err_drop_o[0] pulse after edge 12, err_sticky_o[0]=1, ch1 unaffected.
- Timeout, req held with no ack:
  - `RAM_S_UNTIL`: err_timeout_o[0] after edge 14.
  - `RAM_UNTIL`: no error, busy_o[0] still 1 at edge 30.
- Ack with req low at the ack-rise edge 13:
  - `RAM_S_UNTIL`: done, latency 3.
  - `RAM_S_UNTIL_WITH`: err_drop_o[0].
- Boundaries:
  - rose(req) and rose(ack) at the same edge → done, latency 0, busy never set.
  - Ack at latency exactly 4 → done, max_lat=4, no timeout.
- Clear and reset:
  - clr_i at the same edge as an err_drop on ch1 → sticky[0]=0, sticky[1]=1.
  - rst_n low mid-WAIT → all outputs 0 immediately, no pulse after release.
